// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system-ID probe master.
package sysid_probe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        DONE
    } probe_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam int   TMO_W         = 8;

endpackage

// File: rtl/sysid_probe_timeout.sv
// Per-read hold-off budget: loadable down-counter that saturates at zero.
// o_expired marks the enabled tick that consumes the last unit of budget.
module sysid_probe_timeout
    import sysid_probe_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [TMO_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // <= 1 rather than == 1 so a counter that somehow sits at zero still fires
    assign o_expired = i_en && (r_cnt <= TMO_W'(1));

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM reader that fetches system ID and build timestamp and checks them.
// Optional SYSID_PROBE_AUTOSTART_EN: launch one probe right after reset release.
module sysid_probe_master
    import sysid_probe_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h694B_C6B6,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    probe_state_e r_state, w_next;
    logic w_start, w_xfer, w_wait, w_expired, w_tmo, w_launch, w_enter_rd;

`ifdef SYSID_PROBE_AUTOSTART_EN
    logic r_first;
    always_ff @(posedge clock) begin
        if (!reset_n) r_first <= 1'b1;
        else          r_first <= 1'b0;
    end
    assign w_start = start | r_first;
`else
    assign w_start = start;
`endif

    assign w_xfer = avm_read & ~avm_waitrequest;
    assign w_wait = avm_read &  avm_waitrequest;
    assign w_tmo  = w_wait & w_expired;

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (w_start) w_next = RD_ID;
            RD_ID: begin
                if (w_xfer)     w_next = RD_TS;
                else if (w_tmo) w_next = DONE;
            end
            RD_TS: begin
                if (w_xfer)     w_next = CHECK;
                else if (w_tmo) w_next = DONE;
            end
            CHECK:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    assign w_launch   = ((r_state == IDLE) || (r_state == DONE)) && (w_next == RD_ID);
    assign w_enter_rd = (w_next != r_state) && ((w_next == RD_ID) || (w_next == RD_TS));

    sysid_probe_timeout u_tmo (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_load     (w_enter_rd),
        .i_load_val (TMO_W'(TIMEOUT_CYCLES)),
        .i_en       (w_wait),
        .o_expired  (w_expired)
    );

    // Outputs are registered from the next state so the bus strobe lines up with the FSM
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            avm_read    <= (w_next == RD_ID) || (w_next == RD_TS);
            avm_address <= (w_next == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            busy        <= (w_next != IDLE) && (w_next != DONE);
            if (w_launch) begin
                done        <= 1'b0;
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b0;
                id_value    <= '0;
                ts_value    <= '0;
            end
            if ((r_state == RD_ID) && w_xfer) id_value <= avm_readdata;
            if ((r_state == RD_TS) && w_xfer) ts_value <= avm_readdata;
            if (r_state == CHECK) begin
                done  <= 1'b1;
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TS);
            end
            // A timed-out timestamp read still reports the ID already captured
            if (w_tmo) begin
                done        <= 1'b1;
                timeout_err <= 1'b1;
                id_ok       <= (r_state == RD_TS) && (id_value == EXPECTED_ID);
                ts_ok       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sysid_probe_master.sv
// Self-checking bench for sysid_probe_master: directed table, corner sequences, random probes.
module tb_sysid_probe_master;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h694B_C6B6;
    localparam int          TMO    = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;

    always #5 clock = ~clock;

    sysid_probe_master #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    // Slave model: holds each read off for sl_wait[addr] cycles, then returns sl_data[addr]
    logic [31:0] sl_data [2];
    int          sl_wait [2];
    int          held, xfer_cnt, ts_cnt, stab_err;
    bit          hold_prev, addr_prev;

    always_comb begin
        avm_waitrequest = avm_read && (held < sl_wait[avm_address]);
        avm_readdata    = avm_read ? sl_data[avm_address] : 32'hDEAD_BEEF;
    end

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) held <= held + 1;
        else                             held <= 0;
        if (avm_read && !avm_waitrequest) xfer_cnt <= xfer_cnt + 1;
        if (avm_read && avm_address)      ts_cnt   <= ts_cnt + 1;
        if (hold_prev && avm_read && (avm_address != addr_prev)) stab_err <= stab_err + 1;
        hold_prev <= avm_read && avm_waitrequest;
        addr_prev <= avm_address;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] idw, tsw;
        int          wid, wts, pulse;
        logic        idok, tsok, tmo;
        logic [31:0] exp_id, exp_ts;
        int          lat, nx, nts;
    } vec_t;

    // lat counts edges from the start-sampling edge E through the edge after which done is seen
    function automatic vec_t ref_model(input vec_t v);
        vec_t m;
        m = v;
        if (v.wid >= TMO) begin
            m.tmo = 1'b1; m.idok = 1'b0; m.tsok = 1'b0;
            m.exp_id = '0; m.exp_ts = '0;
            m.lat = TMO + 1; m.nx = 0; m.nts = 0;
        end else begin
            m.tmo = 1'b0;
            m.idok = (v.idw == EXP_ID);
            m.tsok = (v.tsw == EXP_TS);
            m.exp_id = v.idw; m.exp_ts = v.tsw;
            m.lat = v.wid + v.wts + 4; m.nx = 2; m.nts = v.wts + 1;
        end
        return m;
    endfunction

    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(posedge clock); @(negedge clock); n++;
        end while (!done && n < 400);
        if (!done) chk({tag, "_done_bound"}, done, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, x0, t0;
        sl_data[0] = v.idw; sl_data[1] = v.tsw;
        sl_wait[0] = v.wid; sl_wait[1] = v.wts;
        x0 = xfer_cnt; t0 = ts_cnt;
        start = 1'b1;
        lat = 0;
        do begin
            @(posedge clock); @(negedge clock); lat++;
            start = (lat == v.pulse);
        end while (!done && lat < 400);
        start = 1'b0;
        chk({tag, "_lat"},   lat, v.lat);
        chk({tag, "_idok"},  id_ok, v.idok);
        chk({tag, "_tsok"},  ts_ok, v.tsok);
        chk({tag, "_tmo"},   timeout_err, v.tmo);
        chk({tag, "_idval"}, id_value, v.exp_id);
        chk({tag, "_tsval"}, ts_value, v.exp_ts);
        chk({tag, "_xfers"}, xfer_cnt - x0, v.nx);
        chk({tag, "_tscyc"}, ts_cnt - t0, v.nts);
        chk({tag, "_idle"},  {busy, avm_read}, 2'b00);
    endtask

    task automatic apply_reset(input string tag);
        int n;
        reset_n = 1'b0; start = 1'b0;
        @(posedge clock); @(negedge clock);
        chk({tag, "_rst_flags"}, {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err}, '0);
        chk({tag, "_rst_id"}, id_value, '0);
        chk({tag, "_rst_ts"}, ts_value, '0);
        @(posedge clock); @(negedge clock);
        reset_n = 1'b1;
`ifdef SYSID_PROBE_AUTOSTART_EN
        @(posedge clock); @(negedge clock);
        chk({tag, "_autostart_read"}, avm_read, 1'b1);
        wait_done({tag, "_autostart"}, n);
        chk({tag, "_autostart_done"}, done, 1'b1);
`else
        n = 0;
        repeat (100) begin
            @(posedge clock); @(negedge clock);
            if (avm_read || busy) n++;
        end
        chk({tag, "_stay_idle"}, n, 0);
`endif
    endtask

    vec_t tbl [8];
    vec_t r;
    int   n;

    initial begin
        tbl[0] = '{EXP_ID, EXP_TS, 0, 0, -1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 4, 2, 1};
        tbl[1] = '{32'h1, EXP_TS, 0, 0, -1, 1'b0, 1'b1, 1'b0, 32'h1, EXP_TS, 4, 2, 1};
        tbl[2] = '{EXP_ID, EXP_TS, 5, 5, -1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 14, 2, 6};
        tbl[3] = '{EXP_ID, EXP_TS, 255, 0, -1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 17, 0, 0};
        tbl[4] = '{EXP_ID, 32'h694B_C6B7, 1, 2, -1, 1'b1, 1'b0, 1'b0, EXP_ID, 32'h694B_C6B7, 7, 2, 3};
        tbl[5] = '{EXP_ID, EXP_TS, 15, 15, -1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 34, 2, 16};
        tbl[6] = '{EXP_ID, EXP_TS, 16, 0, -1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 17, 0, 0};
        tbl[7] = '{32'hFFFF_FFFF, 32'h0, 2, 2, 3, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 8, 2, 3};

        sl_data[0] = EXP_ID; sl_data[1] = EXP_TS;
        sl_wait[0] = 0;      sl_wait[1] = 0;
        @(negedge clock);
        apply_reset("init");

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // start held high in DONE: one done cycle, then immediate relaunch
        sl_data[0] = EXP_ID; sl_data[1] = EXP_TS; sl_wait[0] = 0; sl_wait[1] = 0;
        start = 1'b1;
        wait_done("restart", n);
        chk("restart_lat", n, 4);
        @(posedge clock); @(negedge clock);
        chk("restart_relaunch", {done, busy, avm_read}, 3'b011);
        start = 1'b0;
        wait_done("restart2", n);
        chk("restart_flags", {id_ok, ts_ok, timeout_err}, 3'b110);

        // reset while the timestamp read is being held off
        sl_wait[1] = 10;
        start = 1'b1;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
        repeat (2) begin @(posedge clock); @(negedge clock); end
        chk("midrst_in_ts", {avm_read, avm_address}, 2'b11);
        apply_reset("midrst");
        run_vec(tbl[0], "after_rst");

        for (int i = 0; i < 30; i++) begin
            r.idw   = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom();
            r.tsw   = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom();
            r.wid   = ($urandom_range(0, 7) == 0) ? TMO + $urandom_range(0, 4) : $urandom_range(0, 4);
            r.wts   = $urandom_range(0, 4);
            r.pulse = $urandom_range(1, 3);
            r = ref_model(r);
            run_vec(r, $sformatf("rnd%0d", i));
        end

        chk("addr_stable_under_wait", stab_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end

endmodule
